// File: rtl/debounce_pkg.sv
// Shared types and constants for the pushbutton / switch debouncer.
`timescale 1ns/1ps
package debounce_pkg;

  // Per-channel debounce state; ARM_* states mean a new level is being qualified
  typedef enum logic [1:0] {
    LOW    = 2'd0,
    ARM_HI = 2'd1,
    HIGH   = 2'd2,
    ARM_LO = 2'd3
  } db_state_t;

  // Board defaults: 1 ms of stability at 50 MHz
  localparam int CNT_W_DEF      = 16;
  localparam int STABLE_CNT_DEF = 50000;

  // Short qualification window used when simulating
  localparam int STABLE_CNT_SIM = 8;

  // True while a channel is qualifying a candidate level
  function automatic logic is_arm(db_state_t s);
    return (s == ARM_HI) || (s == ARM_LO);
  endfunction

endpackage

// File: rtl/db_channel.sv
// Single debounce channel: two-flop synchroniser, 4-state FSM and stability counter.
`timescale 1ns/1ps
module db_channel
  import debounce_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int STABLE_CNT = STABLE_CNT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic arm
);

  // Counter value on the cycle a candidate level is accepted
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic            s1;
  logic            s2;
  db_state_t       state_q;
  db_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic            level_d;
  logic            press_d;
  logic            release_d;

  // Two-flop synchroniser; only s2 is ever seen by the FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // State, counter and registered outputs; reset discards any progress silently
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= LOW;
      cnt_q         <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      level         <= level_d;
      press         <= press_d;
      release_pulse <= release_d;
    end
  end

  // Next-state logic; a window of one cycle accepts straight from LOW/HIGH
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      LOW: begin
        cnt_d   = '0;
        level_d = 1'b0;
        if (s2) begin
          if (STABLE_CNT == 1) begin
            state_d = HIGH;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            state_d = ARM_HI;
            cnt_d   = ONE_CNT;
          end
        end
      end
      ARM_HI: begin
        if (!s2) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          state_d = HIGH;
          level_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_CNT;
        end
      end
      HIGH: begin
        cnt_d   = '0;
        level_d = 1'b1;
        if (!s2) begin
          if (STABLE_CNT == 1) begin
            state_d   = LOW;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            state_d = ARM_LO;
            cnt_d   = ONE_CNT;
          end
        end
      end
      ARM_LO: begin
        if (s2) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          state_d   = LOW;
          level_d   = 1'b0;
          release_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + ONE_CNT;
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign arm = is_arm(state_q);

endmodule

// File: rtl/pb_debounce.sv
// Multi-channel pushbutton/switch conditioner: N independent debounce channels.
// The release output is named release_pulse because "release" is a reserved word.
`timescale 1ns/1ps
module pb_debounce
  import debounce_pkg::*;
#(
  parameter int N          = 4,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int STABLE_CNT = STABLE_CNT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] raw,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] release_pulse,
  output logic         busy
);

  logic [N-1:0] arm;

  // One fully independent channel per input pin
  for (genvar g = 0; g < N; g++) begin : g_ch
    db_channel #(
      .CNT_W      (CNT_W),
      .STABLE_CNT (STABLE_CNT)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .raw           (raw[g]),
      .level         (level[g]),
      .press         (press[g]),
      .release_pulse (release_pulse[g]),
      .arm           (arm[g])
    );
  end

  // Arm flags come straight from registered state, so busy is glitch-free
  assign busy = |arm;

endmodule

// File: tb/tb_pb_debounce.sv
// Self-checking bench: two debouncer builds (window 8 and window 1) share one raw bus.
`timescale 1ns/1ps
module tb_pb_debounce;
  import debounce_pkg::*;

  localparam int N     = 4;
  localparam int CNT_W = 16;
  localparam int S8    = STABLE_CNT_SIM;
  localparam int S1    = 1;
  localparam int SCFG [2] = '{S8, S1};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] raw = '0;

  logic [N-1:0] level8, press8, rel8;
  logic [N-1:0] level1, press1, rel1;
  logic         busy8, busy1;

  int numChecks  = 0;
  int numFails   = 0;
  int pulseCount = 0;

  always #5 clk = ~clk;

  pb_debounce #(.N(N), .CNT_W(CNT_W), .STABLE_CNT(S8)) dut8 (
    .clk           (clk),
    .rst           (rst),
    .raw           (raw),
    .level         (level8),
    .press         (press8),
    .release_pulse (rel8),
    .busy          (busy8)
  );

  pb_debounce #(.N(N), .CNT_W(CNT_W), .STABLE_CNT(S1)) dut1 (
    .clk           (clk),
    .rst           (rst),
    .raw           (raw),
    .level         (level1),
    .press         (press1),
    .release_pulse (rel1),
    .busy          (busy1)
  );

  // Reference model: the synchronised value x is raw delayed two edges; the level
  // becomes v whenever the last S values of x all equal v, else it holds.
  // A channel is busy when x disagrees with the accepted level.
  logic [N-1:0] ms1 [2];
  logic [N-1:0] ms2 [2];
  logic [N-1:0] mLevel [2];
  logic [N-1:0] mPress [2];
  logic [N-1:0] mRel [2];
  logic         mBusy [2];
  int           runLen [2][N];
  logic         runVal [2][N];

  always @(posedge clk or negedge rst) begin : model_blk
    logic [N-1:0] nl;
    logic         anyArm;
    logic         x;
    int           rl;
    if (!rst) begin
      for (int c = 0; c < 2; c++) begin
        ms1[c]    <= '0;
        ms2[c]    <= '0;
        mLevel[c] <= '0;
        mPress[c] <= '0;
        mRel[c]   <= '0;
        mBusy[c]  <= 1'b0;
        for (int i = 0; i < N; i++) begin
          runLen[c][i] <= 0;
          runVal[c][i] <= 1'b0;
        end
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        anyArm = 1'b0;
        nl     = mLevel[c];
        for (int i = 0; i < N; i++) begin
          x = ms2[c][i];
          if (x == runVal[c][i]) rl = (runLen[c][i] >= 1000) ? 1000 : runLen[c][i] + 1;
          else rl = 1;
          nl[i] = (rl >= SCFG[c]) ? x : mLevel[c][i];
          if (x != nl[i]) anyArm = 1'b1;
          runLen[c][i] <= rl;
          runVal[c][i] <= x;
        end
        mPress[c] <= nl & ~mLevel[c];
        mRel[c]   <= ~nl & mLevel[c];
        mLevel[c] <= nl;
        mBusy[c]  <= anyArm;
        ms2[c]    <= ms1[c];
        ms1[c]    <= raw;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    numChecks++;
    if (got !== exp) begin
      numFails++;
      $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input int cycles);
    raw = v;
    repeat (cycles) @(negedge clk);
  endtask

  // Every-cycle comparison of both builds against the model
  always @(negedge clk) begin
    if ($time > 2) begin
      checkOutput("level8", level8, mLevel[0]);
      checkOutput("press8", press8, mPress[0]);
      checkOutput("rel8",   rel8,   mRel[0]);
      checkOutput("busy8",  {{(N-1){1'b0}}, busy8}, {{(N-1){1'b0}}, mBusy[0]});
      checkOutput("level1", level1, mLevel[1]);
      checkOutput("press1", press1, mPress[1]);
      checkOutput("rel1",   rel1,   mRel[1]);
      checkOutput("busy1",  {{(N-1){1'b0}}, busy1}, {{(N-1){1'b0}}, mBusy[1]});
    end
  end

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_level", level8, 4'b0000);
    checkOutput("reset_press", press8 | rel8, 4'b0000);
    checkOutput("reset_busy",  {3'b000, busy8 | busy1}, 4'b0000);
    #2 rst = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("idle_level", level8 | level1, 4'b0000);

    // Clean press on channel 0
    applyStimulus(4'b0001, 2);
    checkOutput("s1_press_early", press1, 4'b0000);
    @(negedge clk);
    checkOutput("s1_press", press1, 4'b0001);
    checkOutput("busy_arm", {3'b000, busy8}, 4'b0001);
    repeat (6) @(negedge clk);
    checkOutput("press_early", press8, 4'b0000);
    checkOutput("busy_late", {3'b000, busy8}, 4'b0001);
    @(negedge clk);
    checkOutput("press_on_time", press8, 4'b0001);
    checkOutput("level_on_time", level8, 4'b0001);
    checkOutput("busy_done", {3'b000, busy8}, 4'b0000);
    @(negedge clk);
    checkOutput("press_one_cycle", press8, 4'b0000);

    // Bounce on channel 1: toggles every 3 cycles, then a clean rise
    pulseCount = 0;
    for (int t = 0; t < 10; t++) begin
      raw[1] = ~raw[1];
      repeat (3) begin
        @(negedge clk);
        pulseCount += int'(press8[1]);
      end
    end
    checkOutput("bounce_pulses", N'(pulseCount), 4'b0000);
    applyStimulus(4'b0011, 9);
    checkOutput("bounce_press_early", press8, 4'b0000);
    @(negedge clk);
    checkOutput("bounce_press", press8, 4'b0010);

    // Simultaneous release on channels 2 and 3
    applyStimulus(4'b1111, 20);
    applyStimulus(4'b0011, 9);
    checkOutput("rel_early", rel8, 4'b0000);
    @(negedge clk);
    checkOutput("rel_both", rel8, 4'b1100);
    checkOutput("rel_level", level8, 4'b0011);
    checkOutput("rel_no_press", press8, 4'b0000);
    @(negedge clk);
    checkOutput("rel_one_cycle", rel8, 4'b0000);

    // Reset in the middle of qualifying a press
    applyStimulus(4'b0010, 20);
    applyStimulus(4'b0011, 5);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midrst_level", level8 | level1, 4'b0000);
    checkOutput("midrst_pulses", press8 | rel8 | press1 | rel1, 4'b0000);
    #2 rst = 1'b1;
    repeat (9) @(negedge clk);
    checkOutput("midrst_press_early", press8, 4'b0000);
    @(negedge clk);
    checkOutput("midrst_press", press8, 4'b0011);

    // One-cycle glitch: invisible to the 8-cycle build, press+release on the 1-cycle build
    applyStimulus(4'b0000, 20);
    applyStimulus(4'b0001, 1);
    applyStimulus(4'b0000, 1);
    checkOutput("glitch_early", press1, 4'b0000);
    @(negedge clk);
    checkOutput("glitch_press", press1, 4'b0001);
    @(negedge clk);
    checkOutput("glitch_release", rel1, 4'b0001);
    checkOutput("glitch_no_repress", press1, 4'b0000);
    checkOutput("glitch_s8_level", level8, 4'b0000);

    // Randomised traffic with occasional resets
    for (int t = 0; t < 4000; t++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 11) == 0) raw[i] = ~raw[i];
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        #2 rst = 1'b1;
      end
      @(negedge clk);
    end
    repeat (30) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
